// File: rtl/neck_sample_sched.sv
// neck_sample_sched: per-sample sequencer for ADC -> Kalman -> diff -> judge.
// Makes the sample tick, chains stage enables, flags overrun and timeouts.
// Ports: clk; rst (sync, active-high); enable (run level); clear_err (pulse);
//   adc/filt/dif1/dif2/dif3/judge_done (finish pulses in);
//   en_adc/en_kalman/en_dif/en_judge (1-cycle start pulses out);
//   busy, judge_valid, sample_cnt[15:0], overrun, timeout_err, err_stage[2:0].
module neck_sample_sched #(
  parameter int SAMPLE_DIV = 1000,
  parameter int TIMEOUT    = 256,
  parameter int WARMUP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear_err,
  input  logic        adc_done,
  input  logic        filt_done,
  input  logic        dif1_done,
  input  logic        dif2_done,
  input  logic        dif3_done,
  input  logic        judge_done,
  output logic        en_adc,
  output logic        en_kalman,
  output logic        en_dif,
  output logic        en_judge,
  output logic        busy,
  output logic        judge_valid,
  output logic [15:0] sample_cnt,
  output logic        overrun,
  output logic        timeout_err,
  output logic [2:0]  err_stage
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(TIMEOUT);
  localparam int WW = $clog2(WARMUP + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADC   = 3'd1,
    S_FILT  = 3'd2,
    S_DIF   = 3'd3,
    S_JUDGE = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [DW-1:0]   r_div;
  logic [TW-1:0]   r_tmo;
  logic [WW-1:0]   r_warm;
  logic            r_d1, r_d2, r_d3;
  logic            r_en_adc, r_en_kal, r_en_dif, r_en_jud;
  logic [15:0]     r_cnt;
  logic            r_ovr, r_tmo_err;
  logic [2:0]      r_err_stage;

  logic w_tick, w_tmo_last, w_dif_all, w_warm_ok;
  logic w_go_adc, w_go_kal, w_go_dif, w_go_jud;
  logic w_tmo_hit, w_sample_ok, w_warm_inc;

  assign w_tick     = enable && (r_div == DW'(SAMPLE_DIV - 1));
  assign w_tmo_last = (r_tmo == TW'(TIMEOUT - 1));
  assign w_warm_ok  = (r_warm >= WW'(WARMUP));
  // Latched finishes plus any arriving this very cycle.
  assign w_dif_all  = (r_d1 | dif1_done) & (r_d2 | dif2_done)
                    & (r_d3 | dif3_done);

  always_comb begin
    w_next      = r_state;
    w_go_adc    = 1'b0;
    w_go_kal    = 1'b0;
    w_go_dif    = 1'b0;
    w_go_jud    = 1'b0;
    w_tmo_hit   = 1'b0;
    w_sample_ok = 1'b0;
    w_warm_inc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_next   = S_ADC;
          w_go_adc = 1'b1;
        end
      end
      S_ADC: begin
        if (adc_done) begin
          w_next   = S_FILT;
          w_go_kal = 1'b1;
        end else if (w_tmo_last) begin
          w_next    = S_IDLE;
          w_tmo_hit = 1'b1;
        end
      end
      S_FILT: begin
        if (filt_done) begin
          w_next   = S_DIF;
          w_go_dif = 1'b1;
        end else if (w_tmo_last) begin
          w_next    = S_IDLE;
          w_tmo_hit = 1'b1;
        end
      end
      S_DIF: begin
        if (w_dif_all) begin
          w_sample_ok = 1'b1;
          if (w_warm_ok) begin
            w_next   = S_JUDGE;
            w_go_jud = 1'b1;
          end else begin
            w_next     = S_IDLE;
            w_warm_inc = 1'b1;
          end
        end else if (w_tmo_last) begin
          w_next    = S_IDLE;
          w_tmo_hit = 1'b1;
        end
      end
      S_JUDGE: begin
        if (judge_done) begin
          w_next = S_IDLE;
        end else if (w_tmo_last) begin
          w_next    = S_IDLE;
          w_tmo_hit = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_tmo       <= '0;
      r_warm      <= '0;
      r_d1        <= 1'b0;
      r_d2        <= 1'b0;
      r_d3        <= 1'b0;
      r_en_adc    <= 1'b0;
      r_en_kal    <= 1'b0;
      r_en_dif    <= 1'b0;
      r_en_jud    <= 1'b0;
      r_cnt       <= '0;
      r_ovr       <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_err_stage <= '0;
    end else begin
      r_state  <= w_next;
      r_en_adc <= w_go_adc;
      r_en_kal <= w_go_kal;
      r_en_dif <= w_go_dif;
      r_en_jud <= w_go_jud;

      if (!enable || w_tick) r_div <= '0;
      else                   r_div <= r_div + 1'b1;

      // Restart the stage timer on every transition.
      if (w_next != r_state || r_state == S_IDLE) r_tmo <= '0;
      else                                        r_tmo <= r_tmo + 1'b1;

      if (w_go_dif) begin
        r_d1 <= 1'b0;
        r_d2 <= 1'b0;
        r_d3 <= 1'b0;
      end else if (r_state == S_DIF) begin
        r_d1 <= r_d1 | dif1_done;
        r_d2 <= r_d2 | dif2_done;
        r_d3 <= r_d3 | dif3_done;
      end

      if (w_sample_ok) r_cnt <= r_cnt + 16'd1;
      if (w_warm_inc && !w_warm_ok) r_warm <= r_warm + 1'b1;

      // A new error beats a coincident clear.
      if (w_tick && r_state != S_IDLE) r_ovr <= 1'b1;
      else if (clear_err)              r_ovr <= 1'b0;

      if (w_tmo_hit) begin
        r_tmo_err <= 1'b1;
        if (!r_tmo_err || clear_err) r_err_stage <= r_state;
      end else if (clear_err) begin
        r_tmo_err   <= 1'b0;
        r_err_stage <= '0;
      end
    end
  end

  assign en_adc      = r_en_adc;
  assign en_kalman   = r_en_kal;
  assign en_dif      = r_en_dif;
  assign en_judge    = r_en_jud;
  assign busy        = (r_state != S_IDLE);
  assign judge_valid = w_warm_ok;
  assign sample_cnt  = r_cnt;
  assign overrun     = r_ovr;
  assign timeout_err = r_tmo_err;
  assign err_stage   = r_err_stage;

endmodule

// File: tb/tb_neck_sample_sched.sv
// tb_neck_sample_sched: randomized bench for neck_sample_sched against a
// sample-level timing model (tick times, stage delays, timeouts).
module tb_neck_sample_sched;

  localparam int SDIV = 16;
  localparam int TMO  = 32;
  localparam int WARM = 2;

  logic clk, rst, enable, clear_err;
  logic adc_done, filt_done, dif1_done, dif2_done, dif3_done, judge_done;
  logic en_adc, en_kalman, en_dif, en_judge, busy, judge_valid;
  logic overrun, timeout_err;
  logic [15:0] sample_cnt;
  logic [2:0]  err_stage;

  neck_sample_sched #(.SAMPLE_DIV(SDIV), .TIMEOUT(TMO), .WARMUP(WARM)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_err(clear_err),
    .adc_done(adc_done), .filt_done(filt_done), .dif1_done(dif1_done),
    .dif2_done(dif2_done), .dif3_done(dif3_done), .judge_done(judge_done),
    .en_adc(en_adc), .en_kalman(en_kalman), .en_dif(en_dif),
    .en_judge(en_judge), .busy(busy), .judge_valid(judge_valid),
    .sample_cnt(sample_cnt), .overrun(overrun), .timeout_err(timeout_err),
    .err_stage(err_stage)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Per-sample stage delays in cycles after the enable; 0 = never finish.
  int da[64], df[64], dd1[64], dd2[64], dd3[64], dj[64];
  int man_c1 = -1, man_c2 = -1, man_c3 = -1;

  // Events encoded as cycle*4 + kind (0 adc, 1 kalman, 2 dif, 3 judge).
  int ob_ev[$];
  int ex_ev[$];
  int ex_cnt, ex_end, x0;
  logic ex_ovr, ex_tmo, ex_valid;
  logic [2:0] ex_stage;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (en_adc)    ob_ev.push_back(cyc * 4 + 0);
    if (en_kalman) ob_ev.push_back(cyc * 4 + 1);
    if (en_dif)    ob_ev.push_back(cyc * 4 + 2);
    if (en_judge)  ob_ev.push_back(cyc * 4 + 3);
  end

  // Stage responder: finish pulse d cycles after each enable.
  initial begin
    int ca, cf, c1, c2, c3, cj, ri, cur;
    ca = 0; cf = 0; c1 = 0; c2 = 0; c3 = 0; cj = 0; ri = 0; cur = 0;
    adc_done = 0; filt_done = 0; judge_done = 0;
    dif1_done = 0; dif2_done = 0; dif3_done = 0;
    forever begin
      @(negedge clk);
      adc_done = 0; filt_done = 0; judge_done = 0;
      dif1_done = (cyc == man_c1);
      dif2_done = (cyc == man_c2);
      dif3_done = (cyc == man_c3);
      if (rst) begin
        ca = 0; cf = 0; c1 = 0; c2 = 0; c3 = 0; cj = 0; ri = 0;
      end else begin
        if (ca > 0) begin ca--; if (ca == 0) adc_done = 1; end
        if (cf > 0) begin cf--; if (cf == 0) filt_done = 1; end
        if (c1 > 0) begin c1--; if (c1 == 0) dif1_done = 1; end
        if (c2 > 0) begin c2--; if (c2 == 0) dif2_done = 1; end
        if (c3 > 0) begin c3--; if (c3 == 0) dif3_done = 1; end
        if (cj > 0) begin cj--; if (cj == 0) judge_done = 1; end
        if (en_adc) begin cur = ri; ri++; ca = da[cur]; end
        if (en_kalman) cf = df[cur];
        if (en_dif) begin c1 = dd1[cur]; c2 = dd2[cur]; c3 = dd3[cur]; end
        if (en_judge) cj = dj[cur];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_delays(input int s, input int a, input int f,
                            input int d1, input int d2, input int d3,
                            input int j);
    da[s] = a; df[s] = f; dd1[s] = d1; dd2[s] = d2; dd3[s] = d3; dj[s] = j;
  endtask

  task automatic fill_delays(input int d, input int j);
    for (int s = 0; s < 64; s++) set_delays(s, d, d, d, d, d, j);
  endtask

  // Sample-level model: ticks at x+15+16k while enabled; a sample runs
  // enable-to-enable with the chosen delays; ticks while busy are overruns.
  task automatic plan(input int x, input int n);
    int be, w, s, a, k, d, m, f, j, tk;
    be = -1; w = 0; s = 0;
    ex_ev.delete();
    ex_cnt = 0; ex_ovr = 0; ex_tmo = 0; ex_stage = 0;
    for (int t = 0; t < n; t++) begin
      tk = x + 15 + SDIV * t;
      if (tk <= be) begin ex_ovr = 1; continue; end
      a = tk + 1;
      ex_ev.push_back(a * 4);
      if (da[s] == 0) begin
        be = a + TMO - 1;
        if (!ex_tmo) ex_stage = 3'd1;
        ex_tmo = 1; s++; continue;
      end
      k = a + da[s] + 1;
      ex_ev.push_back(k * 4 + 1);
      if (df[s] == 0) begin
        be = k + TMO - 1;
        if (!ex_tmo) ex_stage = 3'd2;
        ex_tmo = 1; s++; continue;
      end
      d = k + df[s] + 1;
      ex_ev.push_back(d * 4 + 2);
      if (dd1[s] == 0 || dd2[s] == 0 || dd3[s] == 0) begin
        be = d + TMO - 1;
        if (!ex_tmo) ex_stage = 3'd3;
        ex_tmo = 1; s++; continue;
      end
      m = dd1[s];
      if (dd2[s] > m) m = dd2[s];
      if (dd3[s] > m) m = dd3[s];
      f = d + m;
      ex_cnt++;
      if (w >= WARM) begin
        j = f + 1;
        ex_ev.push_back(j * 4 + 3);
        if (dj[s] == 0) begin
          be = j + TMO - 1;
          if (!ex_tmo) ex_stage = 3'd4;
          ex_tmo = 1;
        end else begin
          be = j + dj[s];
        end
      end else begin
        w++;
        be = f;
      end
      s++;
    end
    ex_end = be;
    ex_valid = (w >= WARM);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; enable = 0; clear_err = 0;
    man_c1 = -1; man_c2 = -1; man_c3 = -1;
    repeat (2) @(negedge clk);
    rst = 0;
    ob_ev.delete();
  endtask

  task automatic go_start(input int n);
    @(negedge clk);
    x0 = cyc;
    plan(x0, n);
    enable = 1;
  endtask

  task automatic go_finish(input int n);
    int last;
    wait_to(x0 + SDIV * n);
    enable = 0;
    last = (ex_end > x0 + SDIV * n) ? ex_end : x0 + SDIV * n;
    wait_to(last + 4);
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; clear_err = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_chk++; if (en_adc !== 1'b0) begin n_fail++; $display("FAIL rst_en_adc got %b exp 0", en_adc); end
    n_chk++; if (en_kalman !== 1'b0) begin n_fail++; $display("FAIL rst_en_kal got %b exp 0", en_kalman); end
    n_chk++; if (en_dif !== 1'b0) begin n_fail++; $display("FAIL rst_en_dif got %b exp 0", en_dif); end
    n_chk++; if (en_judge !== 1'b0) begin n_fail++; $display("FAIL rst_en_jud got %b exp 0", en_judge); end
    n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL rst_jv got %b exp 0", judge_valid); end
    n_chk++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", sample_cnt); end
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr got %b exp 0", overrun); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_tmo got %b exp 0", timeout_err); end
    n_chk++; if (err_stage !== 3'd0) begin n_fail++; $display("FAIL rst_stage got %0d exp 0", err_stage); end
  endtask

  task automatic test_nominal();
    int nj;
    do_reset();
    fill_delays(2, 2);
    go_start(5);
    go_finish(5);
    n_chk++; if (ob_ev.size() !== ex_ev.size()) begin n_fail++; $display("FAIL nom_nev got %0d exp %0d", ob_ev.size(), ex_ev.size()); end
    foreach (ex_ev[i]) if (i < ob_ev.size()) begin
      n_chk++; if (ob_ev[i] !== ex_ev[i]) begin n_fail++; $display("FAIL nom_ev%0d got cyc %0d kind %0d exp cyc %0d kind %0d", i, ob_ev[i] / 4, ob_ev[i] % 4, ex_ev[i] / 4, ex_ev[i] % 4); end
    end
    nj = 0;
    foreach (ob_ev[i]) if (ob_ev[i] % 4 == 3) nj++;
    n_chk++; if (nj !== 3) begin n_fail++; $display("FAIL nom_njudge got %0d exp 3", nj); end
    n_chk++; if (sample_cnt !== 16'd5) begin n_fail++; $display("FAIL nom_cnt got %0d exp 5", sample_cnt); end
    n_chk++; if (judge_valid !== 1'b1) begin n_fail++; $display("FAIL nom_jv got %b exp 1", judge_valid); end
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL nom_ovr got %b exp 0", overrun); end
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 64; s++)
      set_delays(s, $urandom_range(1, 4), $urandom_range(1, 4),
                 $urandom_range(1, 4), $urandom_range(1, 4),
                 $urandom_range(1, 4), $urandom_range(1, 8));
    go_start(16);
    go_finish(16);
    n_chk++; if (ob_ev.size() !== ex_ev.size()) begin n_fail++; $display("FAIL rnd_nev got %0d exp %0d", ob_ev.size(), ex_ev.size()); end
    foreach (ex_ev[i]) if (i < ob_ev.size()) begin
      n_chk++; if (ob_ev[i] !== ex_ev[i]) begin n_fail++; $display("FAIL rnd_ev%0d got cyc %0d kind %0d exp cyc %0d kind %0d", i, ob_ev[i] / 4, ob_ev[i] % 4, ex_ev[i] / 4, ex_ev[i] % 4); end
    end
    n_chk++; if (sample_cnt !== 16'(ex_cnt)) begin n_fail++; $display("FAIL rnd_cnt got %0d exp %0d", sample_cnt, ex_cnt); end
    n_chk++; if (overrun !== ex_ovr) begin n_fail++; $display("FAIL rnd_ovr got %b exp %b", overrun, ex_ovr); end
    n_chk++; if (judge_valid !== ex_valid) begin n_fail++; $display("FAIL rnd_jv got %b exp %b", judge_valid, ex_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_busy got %b exp 0", busy); end
  endtask

  task automatic test_dif_order();
    do_reset();
    fill_delays(1, 1);
    set_delays(2, 1, 1, 3, 3, 1, 1);
    set_delays(3, 1, 1, 2, 2, 2, 1);
    go_start(5);
    go_finish(5);
    n_chk++; if (ob_ev.size() !== ex_ev.size()) begin n_fail++; $display("FAIL dif_nev got %0d exp %0d", ob_ev.size(), ex_ev.size()); end
    foreach (ex_ev[i]) if (i < ob_ev.size()) begin
      n_chk++; if (ob_ev[i] !== ex_ev[i]) begin n_fail++; $display("FAIL dif_ev%0d got cyc %0d kind %0d exp cyc %0d kind %0d", i, ob_ev[i] / 4, ob_ev[i] % 4, ex_ev[i] / 4, ex_ev[i] % 4); end
    end
    if (ob_ev.size() >= 14) begin
      n_chk++; if (ob_ev[9] - ob_ev[8] !== 17) begin n_fail++; $display("FAIL dif_split got delta %0d exp 17", ob_ev[9] - ob_ev[8]); end
      n_chk++; if (ob_ev[13] - ob_ev[12] !== 13) begin n_fail++; $display("FAIL dif_same got delta %0d exp 13", ob_ev[13] - ob_ev[12]); end
    end else begin
      n_chk++; n_fail++;
      $display("FAIL dif_events got %0d exp >=14", ob_ev.size());
    end
  endtask

  task automatic test_timeout();
    int e;
    do_reset();
    fill_delays(1, 1);
    set_delays(0, 1, 0, 1, 1, 1, 1);
    go_start(5);
    e = ex_ev[1] / 4;
    wait_to(e + TMO - 1);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_hold got %b exp 1", busy); end
    wait_to(e + TMO);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_drop got %b exp 0", busy); end
    n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b exp 1", timeout_err); end
    n_chk++; if (err_stage !== 3'd2) begin n_fail++; $display("FAIL tmo_stage got %0d exp 2", err_stage); end
    n_chk++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL tmo_cnt got %0d exp 0", sample_cnt); end
    go_finish(5);
    n_chk++; if (ob_ev.size() !== ex_ev.size()) begin n_fail++; $display("FAIL tmo_nev got %0d exp %0d", ob_ev.size(), ex_ev.size()); end
    foreach (ex_ev[i]) if (i < ob_ev.size()) begin
      n_chk++; if (ob_ev[i] !== ex_ev[i]) begin n_fail++; $display("FAIL tmo_ev%0d got cyc %0d kind %0d exp cyc %0d kind %0d", i, ob_ev[i] / 4, ob_ev[i] % 4, ex_ev[i] / 4, ex_ev[i] % 4); end
    end
    n_chk++; if (sample_cnt !== 16'(ex_cnt)) begin n_fail++; $display("FAIL tmo_cnt_end got %0d exp %0d", sample_cnt, ex_cnt); end
    n_chk++; if (overrun !== ex_ovr) begin n_fail++; $display("FAIL tmo_ovr got %b exp %b", overrun, ex_ovr); end
    n_chk++; if (err_stage !== ex_stage) begin n_fail++; $display("FAIL tmo_stage_end got %0d exp %0d", err_stage, ex_stage); end
  endtask

  task automatic test_overrun();
    do_reset();
    fill_delays(2, 20);
    go_start(6);
    go_finish(6);
    n_chk++; if (ob_ev.size() !== ex_ev.size()) begin n_fail++; $display("FAIL ovr_nev got %0d exp %0d", ob_ev.size(), ex_ev.size()); end
    foreach (ex_ev[i]) if (i < ob_ev.size()) begin
      n_chk++; if (ob_ev[i] !== ex_ev[i]) begin n_fail++; $display("FAIL ovr_ev%0d got cyc %0d kind %0d exp cyc %0d kind %0d", i, ob_ev[i] / 4, ob_ev[i] % 4, ex_ev[i] / 4, ex_ev[i] % 4); end
    end
    n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b exp 1", overrun); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL ovr_tmo got %b exp 0", timeout_err); end
    n_chk++; if (sample_cnt !== 16'(ex_cnt)) begin n_fail++; $display("FAIL ovr_cnt got %0d exp %0d", sample_cnt, ex_cnt); end
    clear_err = 1;
    @(negedge clk);
    clear_err = 0;
    n_chk++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b exp 0", overrun); end
  endtask

  task automatic test_reset_in_dif();
    int sz, k;
    do_reset();
    fill_delays(1, 1);
    set_delays(2, 1, 1, 0, 0, 0, 1);
    go_start(3);
    k = 0;
    while (ob_ev.size() < 9 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_chk++; if (ob_ev.size() < 9) begin n_fail++; $display("FAIL rdif_reach got %0d events exp 9", ob_ev.size()); end
    @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rdif_pre_busy got %b exp 1", busy); end
    n_chk++; if (judge_valid !== 1'b1) begin n_fail++; $display("FAIL rdif_pre_jv got %b exp 1", judge_valid); end
    rst = 1; enable = 0;
    @(negedge clk);
    rst = 0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rdif_busy got %b exp 0", busy); end
    n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL rdif_jv got %b exp 0", judge_valid); end
    n_chk++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL rdif_cnt got %0d exp 0", sample_cnt); end
    n_chk++; if ({en_adc, en_kalman, en_dif, en_judge} !== 4'b0) begin n_fail++; $display("FAIL rdif_en got %b exp 0000", {en_adc, en_kalman, en_dif, en_judge}); end
    sz = ob_ev.size();
    man_c1 = cyc + 1; man_c2 = cyc + 2; man_c3 = cyc + 2;
    repeat (6) @(negedge clk);
    n_chk++; if (ob_ev.size() !== sz) begin n_fail++; $display("FAIL rdif_noen got %0d events exp %0d", ob_ev.size(), sz); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rdif_idle got %b exp 0", busy); end
    n_chk++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL rdif_cnt2 got %0d exp 0", sample_cnt); end
  endtask

  task automatic test_enable_drop();
    int k;
    do_reset();
    fill_delays(2, 2);
    @(negedge clk);
    x0 = cyc;
    enable = 1;
    k = 0;
    while (ob_ev.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    enable = 0;
    repeat (80) @(negedge clk);
    n_chk++; if (ob_ev.size() !== 3) begin n_fail++; $display("FAIL edrop_nev got %0d exp 3", ob_ev.size()); end
    if (ob_ev.size() >= 3) begin
      n_chk++; if (ob_ev[0] !== (x0 + 16) * 4) begin n_fail++; $display("FAIL edrop_adc got cyc %0d exp %0d", ob_ev[0] / 4, x0 + 16); end
      n_chk++; if (ob_ev[2] - ob_ev[1] !== 13) begin n_fail++; $display("FAIL edrop_dif got delta %0d exp 13", ob_ev[2] - ob_ev[1]); end
    end
    n_chk++; if (sample_cnt !== 16'd1) begin n_fail++; $display("FAIL edrop_cnt got %0d exp 1", sample_cnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL edrop_busy got %b exp 0", busy); end
  endtask

  initial begin
    rst = 1; enable = 0; clear_err = 0;
    fill_delays(1, 1);
    test_reset();
    test_nominal();
    test_dif_order();
    test_timeout();
    test_overrun();
    test_reset_in_dif();
    test_enable_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
